// File: rtl/tff_count_sequencer_pkg.sv
// Shared definitions for the T-flip-flop count sequencer: controller state
// encoding and direction codes.
package tff_count_sequencer_pkg;

    // Controller states; encodings are fixed so the state value can be
    // probed or compared against documentation directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Direction codes as carried on the dir input and held for a job.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops. Each bit toggles when its T input is high.
// A shared synchronous clear forces all bits to zero and has priority
// over toggling.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    // Toggle each bit whose T is set; clear wins over any toggle.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_count_sequencer.sv
// Sequences a bank of T flip-flops as a programmable modulo-M up/down
// counter. One job (direction, modulus, step count) is accepted per start
// in IDLE, run for exactly that many edges, and completed with a one-cycle
// done pulse. The counter value is only ever changed by toggling bits or by
// the bank's synchronous clear.
module tff_count_sequencer
    import tff_count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
) (
    input  logic             clk,
    input  logic             syncReset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] modulus,
    input  logic [STEPW-1:0] steps,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] tvec,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state;
    state_t           stateNext;

    logic [STEPW-1:0] remaining;
    logic             dirLat;
    logic [WIDTH-1:0] modLat;

    // Modulus widened by one bit so that a latched 0 can stand for 2^WIDTH.
    logic [WIDTH:0]   modFull;
    logic [WIDTH:0]   lastVal;
    logic [WIDTH:0]   countWide;
    logic [WIDTH-1:0] countNext;
    logic             wrapHit;

    logic             acceptJob;
    logic             clrAccept;
    logic             bankClear;

    // A start in IDLE with a nonzero step count opens a job; clr only acts
    // in IDLE and only when no start competes with it.
    assign acceptJob = (state == ST_IDLE) && start && (steps != '0);
    assign clrAccept = (state == ST_IDLE) && clr && !start;
    assign bankClear = syncReset || clrAccept;

    tff_bank #(
        .WIDTH(WIDTH)
    ) uBank (
        .clk  (clk),
        .clear(bankClear),
        .t    (tvec),
        .q    (count)
    );

    // Compute the next count value and whether this step wraps.
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        modFull   = {1'b0, modLat};
        if (modLat == '0) begin
            modFull = {1'b1, {WIDTH{1'b0}}};
        end
        lastVal   = modFull - {{WIDTH{1'b0}}, 1'b1};
        countWide = {1'b0, count};
        countNext = count;
        wrapHit   = 1'b0;

        if (dirLat == DIR_UP) begin
            // Reaching the top, or starting out of range, lands on zero.
            if (countWide >= lastVal) begin
                countNext = '0;
                wrapHit   = 1'b1;
            end else begin
                countNext = count + WIDTH'(1);
            end
        end else begin
            // Only a genuine 0 -> M-1 step counts as a wrap; an
            // out-of-range value is corrected to M-1 without one.
            if (count == '0) begin
                countNext = lastVal[WIDTH-1:0];
                wrapHit   = 1'b1;
            end else if (countWide >= modFull) begin
                countNext = lastVal[WIDTH-1:0];
            end else begin
                countNext = count - WIDTH'(1);
            end
        end
    end

    // Toggle exactly the bits that differ between now and next, only in RUN.
    always_comb begin
        tvec = '0;
        if (state == ST_RUN) begin
            tvec = count ^ countNext;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (syncReset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stateNext = (steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (remaining == STEPW'(1)) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Job parameters, remaining-step counter and the registered wrap pulse.
    always_ff @(posedge clk) begin
        if (syncReset) begin
            remaining <= '0;
            dirLat    <= DIR_DOWN;
            modLat    <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= (state == ST_RUN) && wrapHit;
            if (acceptJob) begin
                remaining <= steps;
                dirLat    <= dir;
                modLat    <= modulus;
            end else if (state == ST_RUN) begin
                remaining <= remaining - STEPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Self-checking bench for tff_count_sequencer: directed scenarios followed
// by randomized jobs, compared every cycle against a behavioural model that
// tracks the count as plain modular arithmetic.
module tb_tff_count_sequencer;

    localparam int W = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          syncReset;
    logic          start;
    logic          dir;
    logic [W-1:0]  modulus;
    logic [SW-1:0] steps;
    logic          clr;
    logic [W-1:0]  count;
    logic [W-1:0]  tvec;
    logic          busy;
    logic          done;
    logic          wrap;

    int nPass = 0;
    int nTotal = 0;
    int wrapSeen = 0;

    // Model: phase 0 = idle, 1 = counting, 2 = finishing.
    int mPhase = 0;
    int mCount = 0;
    int mLeft  = 0;
    int mMod   = 16;
    bit mUp    = 1'b0;
    bit mWrap  = 1'b0;

    tff_count_sequencer #(.WIDTH(W), .STEPW(SW)) dut (
        .clk      (clk),
        .syncReset(syncReset),
        .start    (start),
        .dir      (dir),
        .modulus  (modulus),
        .steps    (steps),
        .clr      (clr),
        .count    (count),
        .tvec     (tvec),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            nPass++;
        end
    endtask

    // Next count in a ring of m values; anything outside the ring snaps to
    // the ring's entry point for that direction.
    function automatic int modelNext(int c, int m, bit up);
        if (up) return (c < m) ? (c + 1) % m : 0;
        return (c < m) ? (c + m - 1) % m : m - 1;
    endfunction

    // Drive one cycle of inputs, advance the model, then compare outputs.
    task automatic tick(input bit st, input bit d, input logic [W-1:0] mo,
                        input logic [SW-1:0] sp, input bit cl, input bit rs);
        start = st; dir = d; modulus = mo; steps = sp; clr = cl; syncReset = rs;
        if (rs) begin
            mPhase = 0; mCount = 0; mLeft = 0; mMod = 16; mUp = 1'b0; mWrap = 1'b0;
        end else begin
            case (mPhase)
                0: begin
                    mWrap = 1'b0;
                    if (st) begin
                        if (sp != 0) begin
                            mUp = d; mMod = (mo == 0) ? 16 : int'(mo); mLeft = int'(sp); mPhase = 1;
                        end else begin
                            mPhase = 2;
                        end
                    end else if (cl) begin
                        mCount = 0;
                    end
                end
                1: begin
                    mWrap  = mUp ? (mCount >= mMod - 1) : (mCount == 0);
                    mCount = modelNext(mCount, mMod, mUp);
                    mLeft--;
                    if (mLeft == 0) mPhase = 2;
                end
                default: begin
                    mWrap = 1'b0;
                    mPhase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (wrap === 1'b1) wrapSeen++;
        check("count", 32'(count), 32'(mCount));
        check("busy",  32'(busy),  32'(mPhase != 0));
        check("done",  32'(done),  32'(mPhase == 2));
        check("wrap",  32'(wrap),  32'(mWrap));
        check("tvec",  32'(tvec),
              (mPhase == 1) ? 32'((mCount ^ modelNext(mCount, mMod, mUp)) & 15) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Start a job, let it run to completion and return to idle.
    task automatic runJob(input bit d, input logic [W-1:0] mo, input logic [SW-1:0] sp);
        tick(1'b1, d, mo, sp, 1'b0, 1'b0);
        idle(int'(sp) + 1);
    endtask

    initial begin
        start = 0; dir = 0; modulus = 0; steps = 0; clr = 0; syncReset = 1;

        // Reset state.
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);

        // Up count with wrap at M=10.
        clear();
        wrapSeen = 0;
        tick(1'b1, 1'b1, 4'd10, 8'd12, 1'b0, 1'b0);
        check("up_busy_latency", 32'(busy), 32'd1);
        idle(12);
        check("up_done_pulse", 32'(done), 32'd1);
        check("up_final", 32'(count), 32'd2);
        check("up_wrap_once", 32'(wrapSeen), 32'd1);
        idle(1);

        // Down count with modulus 0 (full 16-value ring).
        clear();
        tick(1'b1, 1'b0, 4'd0, 8'd3, 1'b0, 1'b0);
        check("down_first_tvec", 32'(tvec), 32'hF);
        idle(1);
        check("down_first", 32'(count), 32'd15);
        check("down_wrap", 32'(wrap), 32'd1);
        idle(2);
        check("down_final", 32'(count), 32'd13);
        idle(1);

        // Zero-step job: straight to done, count untouched.
        tick(1'b1, 1'b1, 4'd3, 8'd0, 1'b0, 1'b0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_count", 32'(count), 32'd13);
        idle(1);

        // Start/clr noise during RUN and DONE is ignored.
        tick(1'b1, 1'b1, 4'd0, 8'd4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 4'd2, 8'd9, 1'b1, 1'b0);
        check("noise_final", 32'(count), 32'd1);

        // Out-of-range correction, up then down.
        clear();
        runJob(1'b1, 4'd0, 8'd12);
        tick(1'b1, 1'b1, 4'd5, 8'd1, 1'b0, 1'b0);
        idle(1);
        check("oor_up_count", 32'(count), 32'd0);
        check("oor_up_wrap", 32'(wrap), 32'd1);
        idle(1);
        clear();
        runJob(1'b1, 4'd0, 8'd12);
        tick(1'b1, 1'b0, 4'd5, 8'd1, 1'b0, 1'b0);
        idle(1);
        check("oor_down_count", 32'(count), 32'd4);
        idle(1);

        // clr alone clears; clr with start is overridden by start.
        clear();
        runJob(1'b1, 4'd0, 8'd7);
        clear();
        check("clr_alone", 32'(count), 32'd0);
        runJob(1'b1, 4'd0, 8'd7);
        tick(1'b1, 1'b1, 4'd0, 8'd3, 1'b1, 1'b0);
        check("clr_start_count", 32'(count), 32'd7);
        check("clr_start_busy", 32'(busy), 32'd1);
        idle(4);

        // Reset mid-job, then a fresh job.
        tick(1'b1, 1'b1, 4'd10, 8'd20, 1'b0, 1'b0);
        idle(5);
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tvec", 32'(tvec), 32'd0);
        runJob(1'b1, 4'd10, 8'd3);
        check("post_rst_job", 32'(count), 32'd3);

        // Randomized jobs with noise and occasional mid-job resets.
        for (int j = 0; j < 60; j++) begin
            automatic bit            d   = 1'($urandom);
            automatic logic [W-1:0]  mo  = W'($urandom);
            automatic logic [SW-1:0] sp  = ($urandom % 5 == 0) ? 8'd0 : SW'($urandom_range(1, 24));
            automatic int            rAt = ($urandom % 8 == 0) ? int'($urandom_range(0, 24)) : -1;
            tick(1'b1, d, mo, sp, 1'($urandom), 1'b0);
            for (int k = 0; k <= int'(sp); k++) begin
                if (k == rAt) begin
                    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
                    break;
                end
                tick(1'($urandom), 1'($urandom), W'($urandom), SW'($urandom), 1'($urandom), 1'b0);
                if (mPhase == 0) break;
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick(1'b0, 1'b0, '0, '0, ($urandom % 4 == 0), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
